// File: rtl/sram_pkg.sv
// Shared types and helpers for the MEM-stage SRAM controller.
// Optional read buffer is enabled with the SRAM_RD_BUFFER_EN macro.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam logic WE_N_RST  = 1'b1;
  localparam logic CTRL_N_ON = 1'b0;

  function automatic int beats_f(input int dw, input int sw);
    return dw / sw;
  endfunction

  function automatic int beat_len_f(input int wc);
    return wc + 1;
  endfunction

  function automatic int cw_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_mem_ctrl_beat_timer.sv
// Beat and in-beat cycle counter for one SRAM access.
// Restarts on start, advances while en is high, wraps after the last beat.
module sram_beat_timer
  import sram_pkg::*;
#(
  parameter int BEATS    = 2,
  parameter int BEAT_LEN = 3,
  localparam int BW      = cw_f(BEATS),
  localparam int CW      = cw_f(BEAT_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          en,
  output logic [BW-1:0] beat,
  output logic          last_cycle,
  output logic          next_last,
  output logic          last_beat
);

  localparam logic [BW-1:0] BMAX = BW'(BEATS - 1);
  localparam logic [CW-1:0] CMAX = CW'(BEAT_LEN - 1);
  localparam logic [CW-1:0] CPRE = CW'(BEAT_LEN - 2);

  logic [BW-1:0] beat_q, beat_d;
  logic [CW-1:0] cyc_q, cyc_d;

  always_comb begin
    beat_d = beat_q;
    cyc_d  = cyc_q;
    if (start) begin
      beat_d = '0;
      cyc_d  = '0;
    end else if (en) begin
      if (last_cycle) begin
        cyc_d  = '0;
        beat_d = last_beat ? '0 : beat_q + BW'(1);
      end else begin
        cyc_d = cyc_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q <= '0;
      cyc_q  <= '0;
    end else begin
      beat_q <= beat_d;
      cyc_q  <= cyc_d;
    end
  end

  assign beat       = beat_q;
  assign last_cycle = (cyc_q == CMAX);
  assign next_last  = (cyc_q == CPRE);
  assign last_beat  = (beat_q == BMAX);

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage SRAM controller: splits one load/store into timed SRAM beats.
// Macro SRAM_RD_BUFFER_EN adds a one-entry read buffer.
module sram_mem_ctrl
  import sram_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          SRAM_DW     = 16,
  parameter int          ADDR_W      = 18,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdEn,
  input  logic                wrEn,
  input  logic [31:0]         addr,
  input  logic [DATA_W-1:0]   wrData,
  output logic [DATA_W-1:0]   rdData,
  output logic                ready,
  output logic                freeze,
  inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N
);

  localparam int BEATS    = beats_f(DATA_W, SRAM_DW);
  localparam int BEAT_LEN = beat_len_f(WAIT_CYCLES);
  localparam int BW       = cw_f(BEATS);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wsh_q, wsh_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic              we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;

  logic              req, hit, start, in_acc;
  logic [31:0]       req_word;
  logic [BW-1:0]     beat;
  logic              last_cycle, next_last, last_beat;

  assign req      = rdEn | wrEn;
  assign req_word = (addr - BASE_ADDR) >> 2;
  assign in_acc   = (state_q == ACCESS);
  assign start    = (state_q == IDLE) & req & ~hit;

  sram_beat_timer #(
    .BEATS    (BEATS),
    .BEAT_LEN (BEAT_LEN)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .en         (in_acc),
    .beat       (beat),
    .last_cycle (last_cycle),
    .next_last  (next_last),
    .last_beat  (last_beat)
  );

`ifdef SRAM_RD_BUFFER_EN
  logic              buf_v_q, buf_v_d;
  logic [31:0]       buf_w_q, buf_w_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [31:0]       word_q, word_d;
  logic              fill;

  assign hit  = rdEn & ~wrEn & buf_v_q & (buf_w_q == req_word);
  assign fill = in_acc & last_cycle & last_beat & ~wr_q;

  always_comb begin
    buf_v_d    = buf_v_q;
    buf_w_d    = buf_w_q;
    buf_data_d = buf_data_q;
    word_d     = word_q;
    if (start) word_d = req_word;
    if (start & wrEn & (req_word == buf_w_q)) buf_v_d = 1'b0;
    if (fill) begin
      buf_v_d    = 1'b1;
      buf_w_d    = word_q;
      buf_data_d = rd_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_v_q    <= 1'b0;
      buf_w_q    <= '0;
      buf_data_q <= '0;
      word_q     <= '0;
    end else begin
      buf_v_q    <= buf_v_d;
      buf_w_q    <= buf_w_d;
      buf_data_q <= buf_data_d;
      word_q     <= word_d;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    wsh_d       = wsh_q;
    asm_d       = asm_q;
    rd_data_d   = rd_data_q;
    sram_addr_d = sram_addr_q;
    we_n_d      = we_n_q;
    dq_oe_d     = dq_oe_q;
    unique case (state_q)
      IDLE: begin
`ifdef SRAM_RD_BUFFER_EN
        if (hit) begin
          state_d   = DONE;
          rd_data_d = buf_data_q;
        end
`endif
        if (start) begin
          state_d     = ACCESS;
          wr_d        = wrEn;
          wsh_d       = wrData;
          sram_addr_d = ADDR_W'(req_word * 32'(BEATS));
          we_n_d      = ~wrEn;
          dq_oe_d     = wrEn;
        end
      end
      ACCESS: begin
        // WE_N rises for the final (hold) cycle of each write beat
        if (wr_q) we_n_d = last_cycle ? last_beat : next_last;
        if (last_cycle) begin
          wsh_d = wsh_q >> SRAM_DW;
          if (!wr_q) asm_d[beat*SRAM_DW +: SRAM_DW] = SRAM_DQ;
          if (last_beat) begin
            state_d = DONE;
            dq_oe_d = 1'b0;
            we_n_d  = WE_N_RST;
            if (!wr_q) rd_data_d = asm_d;
          end else begin
            sram_addr_d = sram_addr_q + ADDR_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      wsh_q       <= '0;
      asm_q       <= '0;
      rd_data_q   <= '0;
      sram_addr_q <= '0;
      we_n_q      <= WE_N_RST;
      dq_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      wsh_q       <= wsh_d;
      asm_q       <= asm_d;
      rd_data_q   <= rd_data_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? wsh_q[SRAM_DW-1:0] : {SRAM_DW{1'bz}};
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_CE_N = CTRL_N_ON;
  assign SRAM_OE_N = CTRL_N_ON;
  assign SRAM_UB_N = CTRL_N_ON;
  assign SRAM_LB_N = CTRL_N_ON;
  assign rdData    = rd_data_q;
  assign ready     = (state_q == DONE);
  assign freeze    = rst & (start | in_acc);

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl: 16-bit/2-wait and 8-bit/1-wait instances
// sharing one expectation queue, each with a behavioural SRAM on its bus.
module tb_sram_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        rd1 = 0, wr1 = 0, rd2 = 0, wr2 = 0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata1, rdata2;
  logic        rdy1, rdy2, frz1, frz2;
  wire  [15:0] dq1;
  wire  [7:0]  dq2;
  logic [17:0] a1, a2;
  logic        ub1, lb1, we1, ce1, oe1;
  logic        ub2, lb2, we2, ce2, oe2;

  sram_mem_ctrl u_dut1 (
    .clk(clk), .rst(rst), .rdEn(rd1), .wrEn(wr1), .addr(addr),
    .wrData(wdata), .rdData(rdata1), .ready(rdy1), .freeze(frz1),
    .SRAM_DQ(dq1), .SRAM_ADDR(a1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1),
    .SRAM_WE_N(we1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
  );

  sram_mem_ctrl #(.SRAM_DW(8), .WAIT_CYCLES(1)) u_dut2 (
    .clk(clk), .rst(rst), .rdEn(rd2), .wrEn(wr2), .addr(addr),
    .wrData(wdata), .rdData(rdata2), .ready(rdy2), .freeze(frz2),
    .SRAM_DQ(dq2), .SRAM_ADDR(a2), .SRAM_UB_N(ub2), .SRAM_LB_N(lb2),
    .SRAM_WE_N(we2), .SRAM_CE_N(ce2), .SRAM_OE_N(oe2)
  );

  for (genvar i = 0; i < 16; i++) begin : g_pu1
    pullup (dq1[i]);
  end
  for (genvar i = 0; i < 8; i++) begin : g_pu2
    pullup (dq2[i]);
  end

  logic [15:0] mem1 [0:262143];
  logic [7:0]  mem2 [0:262143];
  logic        drv1 = 0, drv2 = 0;
  assign dq1 = drv1 ? mem1[a1] : 16'hzzzz;
  assign dq2 = drv2 ? mem2[a2] : 8'hzz;

  always @(negedge clk) begin
    if (!we1) mem1[a1] <= dq1;
    if (!we2) mem2[a2] <= dq2;
  end

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          frz;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0, miscompares = 0;
  bit          busy = 0, sel = 0, rd_mode = 0;
  int          lat = 0, frz_n = 0;
  logic [31:0] ref1 [int];
  logic [31:0] ref2 [int];
  logic [31:0] last1 = '0, last2 = '0;
`ifdef SRAM_RD_BUFFER_EN
  bit          buf_v = 0;
  int          buf_w = 0;
`endif

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] rd;
    bit          d;
    int          bl;
    if (!rst) begin
      lat = 0; frz_n = 0; drv1 = 0; drv2 = 0;
    end else if (busy) begin
      if (rd_mode && !(sel ? drv2 : drv1)) begin
        vectors++;
        if (sel ? (dq2 !== 8'hFF) : (dq1 !== 16'hFFFF)) begin
          miscompares++;
          $display("FAIL dq_release: bus=%h required released", sel ? {8'h0, dq2} : dq1);
        end
      end
      lat++;
      if (sel ? frz2 : frz1) frz_n++;
      if (sel ? rdy2 : rdy1) begin
        rd = sel ? rdata2 : rdata1;
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_ready: lat=%0d required no ready", lat);
        end else begin
          e = exp_q.pop_front();
          vectors += 3;
          if (rd !== e.data) begin
            miscompares++;
            $display("FAIL rdData: got %h required %h", rd, e.data);
          end
          if (lat !== e.lat) begin
            miscompares++;
            $display("FAIL ready_cycle: got %0d required %0d", lat, e.lat);
          end
          if (frz_n !== e.frz) begin
            miscompares++;
            $display("FAIL freeze_len: got %0d required %0d", frz_n, e.frz);
          end
        end
        busy = 0; lat = 0; frz_n = 0; drv1 = 0; drv2 = 0;
      end else begin
        bl = sel ? 2 : 3;
        d  = rd_mode && (sel ? frz2 : frz1) && lat >= 2 && ((lat - 2) % bl != 0);
        if (sel) drv2 = d; else drv1 = d;
      end
    end
  end

  task automatic access(input bit s, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] dat);
    exp_t e;
    int   w, bl, nb;
    bit   hit;
    w   = int'((a - 32'd1024) >> 2);
    hit = 0;
`ifdef SRAM_RD_BUFFER_EN
    hit = !s && rd && !wr && buf_v && (buf_w == w);
`endif
    if (wr) begin
      if (s) ref2[w] = dat; else ref1[w] = dat;
      e.data = s ? last2 : last1;
`ifdef SRAM_RD_BUFFER_EN
      if (!s && w == buf_w) buf_v = 0;
`endif
    end else begin
      e.data = s ? ref2[w] : ref1[w];
      if (s) last2 = e.data; else last1 = e.data;
`ifdef SRAM_RD_BUFFER_EN
      if (!s) begin buf_v = 1; buf_w = w; end
`endif
    end
    bl    = s ? 2 : 3;
    nb    = s ? 4 : 2;
    e.frz = hit ? 0 : 1 + nb * bl;
    e.lat = hit ? 2 : e.frz + 1;
    @(posedge clk); #1;
    addr = a; wdata = dat;
    if (s) begin rd2 = rd; wr2 = wr; end
    else begin rd1 = rd; wr1 = wr; end
    sel = s; rd_mode = rd && !wr;
    exp_q.push_back(e);
    busy = 1;
    @(posedge clk); #1;
    rd1 = 0; wr1 = 0; rd2 = 0; wr2 = 0;
    for (int i = 0; i < 40 && busy; i++) @(posedge clk);
    if (busy) begin
      vectors++; miscompares++;
      $display("FAIL timeout: no ready within 40 cycles, addr=%h", a);
      busy = 0;
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #12;
    vectors += 8;
    if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL rst_rdData: got %h required 0", rdata1); end
    if (rdata2 !== 32'h0) begin miscompares++; $display("FAIL rst_rdData2: got %h required 0", rdata2); end
    if (rdy1 !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b required 0", rdy1); end
    if (frz1 !== 1'b0) begin miscompares++; $display("FAIL rst_freeze: got %b required 0", frz1); end
    if (we1 !== 1'b1) begin miscompares++; $display("FAIL rst_we_n: got %b required 1", we1); end
    if (a1 !== 18'h0) begin miscompares++; $display("FAIL rst_addr: got %h required 0", a1); end
    if (dq1 !== 16'hFFFF) begin miscompares++; $display("FAIL rst_dq: got %h required released", dq1); end
    if ({ce1, oe1, ub1, lb1} !== 4'b0) begin
      miscompares++; $display("FAIL rst_ctrl: got %b required 0000", {ce1, oe1, ub1, lb1});
    end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write();
    access(0, 0, 1, 32'd1024, 32'hDEADBEEF);
    vectors += 2;
    if (mem1[0] !== 16'hBEEF) begin miscompares++; $display("FAIL wr_beat0: got %h required beef", mem1[0]); end
    if (mem1[1] !== 16'hDEAD) begin miscompares++; $display("FAIL wr_beat1: got %h required dead", mem1[1]); end
  endtask

  task automatic test_read();
    access(0, 1, 0, 32'd1024, 32'h0);
  endtask

  task automatic test_rd_wr_priority();
    access(0, 1, 1, 32'd1028, 32'h12345678);
    vectors += 2;
    if (mem1[2] !== 16'h5678) begin miscompares++; $display("FAIL prio_beat0: got %h required 5678", mem1[2]); end
    if (mem1[3] !== 16'h1234) begin miscompares++; $display("FAIL prio_beat1: got %h required 1234", mem1[3]); end
  endtask

  task automatic test_reset_mid_write();
    @(posedge clk); #1;
    addr = 32'd1036; wdata = 32'h0; wr1 = 1;
    @(posedge clk); #1;
    wr1 = 0;
    vectors += 2;
    if (we1 !== 1'b0) begin miscompares++; $display("FAIL mid_we_low: got %b required 0", we1); end
    if (dq1 !== 16'h0000) begin miscompares++; $display("FAIL mid_dq_drive: got %h required 0000", dq1); end
    #2 rst = 1'b0;
    #1;
    vectors += 5;
    if (we1 !== 1'b1) begin miscompares++; $display("FAIL mid_rst_we_n: got %b required 1", we1); end
    if (dq1 !== 16'hFFFF) begin miscompares++; $display("FAIL mid_rst_dq: got %h required released", dq1); end
    if (frz1 !== 1'b0) begin miscompares++; $display("FAIL mid_rst_freeze: got %b required 0", frz1); end
    if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL mid_rst_rdData: got %h required 0", rdata1); end
    if (a1 !== 18'h0) begin miscompares++; $display("FAIL mid_rst_addr: got %h required 0", a1); end
    @(negedge clk); rst = 1'b1;
    last1 = '0; last2 = '0;
`ifdef SRAM_RD_BUFFER_EN
    buf_v = 0;
`endif
    @(negedge clk);
    vectors += 2;
    if (frz1 !== 1'b0) begin miscompares++; $display("FAIL post_rst_idle: got %b required 0", frz1); end
    if (rdy1 !== 1'b0) begin miscompares++; $display("FAIL post_rst_ready: got %b required 0", rdy1); end
  endtask

  task automatic test_narrow();
    access(1, 0, 1, 32'd1024, 32'hA1B2C3D4);
    vectors += 4;
    if (mem2[0] !== 8'hD4) begin miscompares++; $display("FAIL nar_b0: got %h required d4", mem2[0]); end
    if (mem2[1] !== 8'hC3) begin miscompares++; $display("FAIL nar_b1: got %h required c3", mem2[1]); end
    if (mem2[2] !== 8'hB2) begin miscompares++; $display("FAIL nar_b2: got %h required b2", mem2[2]); end
    if (mem2[3] !== 8'hA1) begin miscompares++; $display("FAIL nar_b3: got %h required a1", mem2[3]); end
    access(1, 1, 0, 32'd1024, 32'h0);
  endtask

  task automatic test_rd_buffer();
    access(0, 1, 0, 32'd1024, 32'h0);
    access(0, 1, 0, 32'd1024, 32'h0);
    access(0, 0, 1, 32'd1024, 32'h1);
    access(0, 1, 0, 32'd1024, 32'h0);
    access(0, 1, 0, 32'd1028, 32'h0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rd_wr_priority();
    test_reset_mid_write();
    test_narrow();
    test_rd_buffer();
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL leftover: %0d pending expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
